pulse_frontend: RTL and testbench
=================================

// Module: pulse_frontend
// PURPOSE
//  Per-channel photon-pulse front end that sits between the raw detector inputs and the correlator core.
//  Generalises the fixed one-stage sync/edge detector to an N-channel front end with:
//  - configurable synchroniser depth and input polarity
//  - per-channel dead time
//  - per-channel runtime-programmable delay (cable/path equalisation)
//  - per-channel saturating event counters, snapshotted on each integration tick
//  Output pulse_out is a one-clk strobe per accepted pulse and feeds the correlator core directly.
// PARAMETERS
//  NUM_INPUTS      12  number of detector channels
//  SYNC_STAGES     2   synchroniser flops per channel (>=2)
//  INPUT_ACTIVE_LOW 1  1: pulse asserted when pin low; 0: asserted when high
//  MAX_DELAY       15  max programmable delay, clk cycles
//  DELAY_W         4   width of delay setting, = clog2(MAX_DELAY+1)
//  DEADTIME        4   cycles after an accepted edge during which further edges are dropped (0 = off)
//  COUNT_W         24  width of each per-channel event counter
//  CH_W            4   width of channel index, = clog2(NUM_INPUTS)
// PORTS
//  clk          in   1                  PLL clock, all logic on rising edge
//  rst          in   1                  synchronous reset, active high
//  pulse_in     in   NUM_INPUTS         asynchronous detector pins
//  cfg_we       in   1                  write strobe for delay register
//  cfg_ch       in   CH_W               channel index for cfg write
//  cfg_delay    in   DELAY_W            delay value, cycles
//  count_latch  in   1                  integration tick, one-clk pulse
//  pulse_out    out  NUM_INPUTS         delayed one-clk strobe per accepted pulse
//  counts       out  NUM_INPUTS*COUNT_W snapshot counts, channel i at [i*COUNT_W +: COUNT_W]
//  counts_valid out  1                  one-clk strobe: counts updated
// BEHAVIOUR
//  Reset:
//  - sync chains load the inactive level (1 if INPUT_ACTIVE_LOW, else 0), so no edge is seen on release.
//  - All of the following clear to 0: edge history, dead-time counters, delay lines, delay regs, running counters, counts, counts_valid, pulse_out.
//  Sync:
//  - SYNC_STAGES flops per channel.
//  - Level s = last stage, polarity-normalised (1 = asserted).
//  Edge:
//  - Raw edge e = s & ~s_prev.
//  - Pulses shorter than one clk may be missed (allowed).
//  Dead time:
//  - Per-channel counter dt.
//  - Accepted a = e & (dt==0).
//  - On a: dt <= DEADTIME.
//  - Else if dt != 0: dt <= dt-1.
//  - Edges with dt != 0 are dropped and not counted.
//  Delay:
//  - Per-channel shift line of MAX_DELAY flops fed by a.
//  - Tap selected by delay reg d; d == 0 outputs a combinationally from the registered edge stage.
//  - Pin-to-pulse_out latency = SYNC_STAGES + 1 + d cycles.
//  - Delays > MAX_DELAY are clamped to MAX_DELAY.
//  Config:
//  - cfg_we with cfg_ch < NUM_INPUTS writes delay reg; new tap is used from the next cycle.
//  - Pulses already in the line keep shifting and may be emitted early, late, or twice across the change (accepted; the host writes only while idle).
//  - cfg_ch >= NUM_INPUTS: write ignored.
//  Counters:
//  - Running counter c_i increments on a_i (pre-delay) and saturates at 2^COUNT_W-1, with no wrap.
//  - On count_latch: counts_i <= c_i + a_i (saturated), so a same-cycle event is included in the snapshot.
//  - c_i then restarts at 0, so no event is lost or double-counted.
//  - counts_valid = 1 in the cycle after count_latch, else 0.
//  - Back-to-back count_latch: each produces its own snapshot and strobe.
//  Reset mid-operation: pulses in flight are discarded and counters are lost; counts_valid stays 0.
// TESTING
//  T1 reset release with pins idle high (ACTIVE_LOW=1) -> pulse_out=0, counts=0, counts_valid=0 for 20 cycles.
//  T2 ch0 delay 0, pin low for 5 clk -> exactly one pulse_out[0] strobe at cycle 3 after the falling edge; no strobe on the rising edge.
//  T3 cfg ch3 delay 7, then pulse ch3 -> strobe at 2+1+7=10 cycles; write with cfg_ch=13 leaves all delays unchanged.
//  T4 DEADTIME=4, ch1 pulses with leading edges 3 cycles apart -> second dropped (one strobe, count +1); 6 cycles apart -> both accepted.
//  T5 ch2 20 pulses, count_latch coincident with the 20th edge -> counts[ch2]=20, counts_valid 1 cycle later; the next window starts at 0.
//  T6 COUNT_W=4, 20 pulses -> count saturates at 15; assert rst mid-pulse -> all outputs 0 next cycle, no spurious strobe after release.

Source files
------------

// File: rtl/pulse_frontend.sv
// pulse_frontend: N-channel detector front end with sync, dead time, programmable delay and snapshot counters
module pulse_frontend #(
  parameter int NUM_INPUTS       = 12,
  parameter int SYNC_STAGES      = 2,
  parameter int INPUT_ACTIVE_LOW = 1,
  parameter int MAX_DELAY        = 15,
  parameter int DELAY_W          = 4,
  parameter int DEADTIME         = 4,
  parameter int COUNT_W          = 24,
  parameter int CH_W             = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_INPUTS-1:0]         pulse_in,
  input  logic                          cfg_we,
  input  logic [CH_W-1:0]               cfg_ch,
  input  logic [DELAY_W-1:0]            cfg_delay,
  input  logic                          count_latch,
  output logic [NUM_INPUTS-1:0]         pulse_out,
  output logic [NUM_INPUTS*COUNT_W-1:0] counts,
  output logic                          counts_valid
);
  localparam int DT_W = $clog2(DEADTIME + 2);
  localparam logic INACTIVE = INPUT_ACTIVE_LOW != 0;
  logic [SYNC_STAGES-1:0] sync_q [NUM_INPUTS];
  logic [SYNC_STAGES-1:0] sync_d [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  s, a, prev_q, prev_d, acc_q, acc_d;
  logic [DT_W-1:0]        dt_q [NUM_INPUTS];
  logic [DT_W-1:0]        dt_d [NUM_INPUTS];
  logic [MAX_DELAY-1:0]   line_q [NUM_INPUTS];
  logic [MAX_DELAY-1:0]   line_d [NUM_INPUTS];
  logic [MAX_DELAY:0]     tap [NUM_INPUTS];
  logic [DELAY_W-1:0]     dly_q [NUM_INPUTS];
  logic [DELAY_W-1:0]     dly_d [NUM_INPUTS];
  logic [COUNT_W-1:0]     cnt_q [NUM_INPUTS];
  logic [COUNT_W-1:0]     cnt_d [NUM_INPUTS];
  logic [COUNT_W-1:0]     snap_q [NUM_INPUTS];
  logic [COUNT_W-1:0]     snap_d [NUM_INPUTS];
  logic [COUNT_W-1:0]     inc [NUM_INPUTS];
  logic                   counts_valid_q, counts_valid_d;
  always_comb begin
    pulse_out = '0;
    counts = '0;
    s = '0;
    a = '0;
    prev_d = '0;
    acc_d = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      sync_d[i] = SYNC_STAGES'({sync_q[i], pulse_in[i]});
      s[i] = sync_q[i][SYNC_STAGES-1] ^ INACTIVE;
      a[i] = s[i] & ~prev_q[i] & (dt_q[i] == '0);
      prev_d[i] = s[i];
      acc_d[i] = a[i];
      dt_d[i] = a[i] ? DT_W'(DEADTIME) : dt_q[i] - DT_W'(dt_q[i] != '0);
      tap[i] = {line_q[i], acc_q[i]};
      line_d[i] = tap[i][MAX_DELAY-1:0];
      pulse_out[i] = tap[i][dly_q[i]];
      dly_d[i] = (cfg_we && 32'(cfg_ch) == i)
               ? ((cfg_delay > DELAY_W'(MAX_DELAY)) ? DELAY_W'(MAX_DELAY) : cfg_delay)
               : dly_q[i];
      inc[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + COUNT_W'(a[i]);
      cnt_d[i] = count_latch ? '0 : inc[i];
      snap_d[i] = count_latch ? inc[i] : snap_q[i];
      counts[i*COUNT_W +: COUNT_W] = snap_q[i];
    end
    counts_valid_d = count_latch;
    counts_valid = counts_valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        sync_q[i] <= {SYNC_STAGES{INACTIVE}};
        dt_q[i] <= '0;
        line_q[i] <= '0;
        dly_q[i] <= '0;
        cnt_q[i] <= '0;
        snap_q[i] <= '0;
      end
      prev_q <= '0;
      acc_q <= '0;
      counts_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        sync_q[i] <= sync_d[i];
        dt_q[i] <= dt_d[i];
        line_q[i] <= line_d[i];
        dly_q[i] <= dly_d[i];
        cnt_q[i] <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
      prev_q <= prev_d;
      acc_q <= acc_d;
      counts_valid_q <= counts_valid_d;
    end
  end
endmodule

// File: tb/tb_pulse_frontend.sv
// tb_pulse_frontend: directed checks of sync latency, delay config, dead time, snapshots, saturation and reset
module tb_pulse_frontend;
  logic          clk = 1'b0;
  logic          rst, rst4;
  logic [11:0]   pulse_in, pulse_in4;
  logic          cfg_we;
  logic [3:0]    cfg_ch, cfg_delay;
  logic          count_latch, count_latch4;
  logic [11:0]   pulse_out, pulse_out4;
  logic [287:0]  counts;
  logic [47:0]   counts4;
  logic          counts_valid, counts_valid4;
  int            n_chk = 0;
  int            n_fail = 0;
  always #5 clk = ~clk;
  pulse_frontend dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay), .count_latch(count_latch), .pulse_out(pulse_out),
    .counts(counts), .counts_valid(counts_valid)
  );
  pulse_frontend #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .pulse_in(pulse_in4), .cfg_we(1'b0), .cfg_ch(4'd0),
    .cfg_delay(4'd0), .count_latch(count_latch4), .pulse_out(pulse_out4),
    .counts(counts4), .counts_valid(counts_valid4)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic flush_window();
    count_latch = 1'b1;
    step(1);
    count_latch = 1'b0;
    step(1);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    rst4 = 1'b1;
    step(3);
    rst = 1'b0;
    rst4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      n_chk++;
      if (pulse_out !== 12'd0 || counts !== 288'd0 || counts_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d pulse_out=%h counts_nz=%b valid=%b want 0", k, pulse_out, counts != 0, counts_valid);
      end
    end
  endtask
  task automatic test_delay0();
    logic [11:0] exp;
    pulse_in[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 5) pulse_in[0] = 1'b1;
      exp = (k == 3) ? 12'h001 : 12'h000;
      n_chk++;
      if (pulse_out !== exp) begin
        n_fail++;
        $display("FAIL delay0 k=%0d got %h want %h", k, pulse_out, exp);
      end
    end
  endtask
  task automatic test_cfg_delay();
    logic [11:0] exp;
    cfg_we = 1'b1;
    cfg_ch = 4'd3;
    cfg_delay = 4'd7;
    step(1);
    cfg_ch = 4'd13;
    cfg_delay = 4'd1;
    step(1);
    cfg_we = 1'b0;
    step(2);
    pulse_in[0] = 1'b0;
    pulse_in[3] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      pulse_in[0] = 1'b1;
      pulse_in[3] = 1'b1;
      exp = 12'h000;
      if (k == 3) exp[0] = 1'b1;
      if (k == 10) exp[3] = 1'b1;
      n_chk++;
      if (pulse_out !== exp) begin
        n_fail++;
        $display("FAIL cfg_delay k=%0d got %h want %h", k, pulse_out, exp);
      end
    end
  endtask
  task automatic test_deadtime(input int gap, input int n_exp);
    logic [11:0] exp;
    flush_window();
    pulse_in[1] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      pulse_in[1] = !(k == gap);
      exp = 12'h000;
      if (k == 3 || (n_exp == 2 && k == gap + 3)) exp[1] = 1'b1;
      n_chk++;
      if (pulse_out !== exp) begin
        n_fail++;
        $display("FAIL deadtime gap=%0d k=%0d got %h want %h", gap, k, pulse_out, exp);
      end
    end
    count_latch = 1'b1;
    step(1);
    count_latch = 1'b0;
    n_chk++;
    if (counts[24 +: 24] !== 24'(n_exp) || counts_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL deadtime_count gap=%0d got %0d valid=%b want %0d valid=1", gap, counts[24 +: 24], counts_valid, n_exp);
    end
    step(1);
    n_chk++;
    if (counts_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL deadtime_valid_drop got %b want 0", counts_valid);
    end
  endtask
  task automatic test_snapshot();
    logic [287:0] exp;
    flush_window();
    for (int k = 0; k <= 127; k++) begin
      if (k > 0) step(1);
      pulse_in[2] = !((k % 6 == 0 && k <= 114) || k == 120);
      count_latch = (k == 116 || k == 124 || k == 125);
      if (k == 117 || k == 125 || k == 126) begin
        exp = '0;
        if (k == 117) exp[48 +: 24] = 24'd20;
        if (k == 125) exp[48 +: 24] = 24'd1;
        n_chk++;
        if (counts !== exp || counts_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL snapshot k=%0d ch2=%0d valid=%b want ch2=%0d valid=1", k, counts[48 +: 24], counts_valid, exp[48 +: 24]);
        end
      end
      if (k == 118 || k == 127) begin
        n_chk++;
        if (counts_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL snapshot_valid k=%0d got %b want 0", k, counts_valid);
        end
      end
    end
  endtask
  task automatic test_saturate_reset();
    for (int k = 0; k <= 150; k++) begin
      if (k > 0) step(1);
      pulse_in4[0] = !((k % 6 == 0 && k <= 114) || (k >= 130 && k <= 133));
      count_latch4 = (k == 120);
      if (k == 132) rst4 = 1'b1;
      if (k == 136) rst4 = 1'b0;
      if (k == 121) begin
        n_chk++;
        if (counts4 !== 48'd15 || counts_valid4 !== 1'b1) begin
          n_fail++;
          $display("FAIL saturate got %h valid=%b want 00000000000f valid=1", counts4, counts_valid4);
        end
      end
      if (k == 133) begin
        n_chk++;
        if (pulse_out4 !== 12'd0 || counts4 !== 48'd0 || counts_valid4 !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_reset pulse_out=%h counts=%h valid=%b want 0", pulse_out4, counts4, counts_valid4);
        end
      end
      if (k >= 137) begin
        n_chk++;
        if (pulse_out4 !== 12'd0 || counts_valid4 !== 1'b0) begin
          n_fail++;
          $display("FAIL post_reset k=%0d pulse_out=%h valid=%b want 0", k, pulse_out4, counts_valid4);
        end
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    rst4 = 1'b1;
    pulse_in = '1;
    pulse_in4 = '1;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_delay = '0;
    count_latch = 1'b0;
    count_latch4 = 1'b0;
    test_reset();
    test_delay0();
    step(5);
    test_cfg_delay();
    step(5);
    test_deadtime(3, 1);
    step(5);
    test_deadtime(6, 2);
    step(5);
    test_snapshot();
    test_saturate_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
